hazard_ctrl: RTL

//  Register-hazard scoreboard/stall controller for the decode stage. Tracks, per

---
 rtl/hazard_ctrl_if.sv | 30 +++
 rtl/hazard_ctrl.sv | 88 ++++++++
 2 files changed

// File: rtl/hazard_ctrl_if.sv
// Decode-stage hazard interface: ID-side request fields in, stall/issue/scoreboard status out.
// master = pipeline control driving decode info, slave = hazard_ctrl.
interface hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_REGS   = 32
);
    logic                  en;
    logic                  flush;
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic                  id_rs1_used;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_rs2_used;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_reg_wr;
    logic                  stall;
    logic                  issue;
    logic [NUM_REGS-1:0]   busy_mask;
    logic                  idle;

    modport master (
        output en, flush, id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used, id_rd, id_reg_wr,
        input  stall, issue, busy_mask, idle
    );

    modport slave (
        input  en, flush, id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used, id_rd, id_reg_wr,
        output stall, issue, busy_mask, idle
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Register-hazard scoreboard and ID stall controller: per-register countdown to writeback.
// Define HAZARD_CTRL_BYPASS_EN when EX->ID forwarding exists (only the adjacent producer blocks).
module hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_REGS   = 32,
    parameter int WB_LAT     = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    hazard_ctrl_if.slave  hz
);
    localparam int CNT_W = $clog2(WB_LAT + 1);
    localparam logic [CNT_W-1:0] LAT = CNT_W'(WB_LAT);

    logic [NUM_REGS-1:0][CNT_W-1:0] w_cnt;
    logic [NUM_REGS-1:0]            w_busy_next;
    logic [NUM_REGS-1:0]            r_busy;
    logic                           r_idle;
    logic                           w_act;
    logic                           w_haz1;
    logic                           w_haz2;
    logic                           w_issue;
    logic                           w_mark;

    function automatic logic blocking(input logic [CNT_W-1:0] c);
`ifdef HAZARD_CTRL_BYPASS_EN
        return c == LAT;
`else
        return c != '0;
`endif
    endfunction

    // Hazard check reads pre-update counts, so rd==rs of one instruction never self-stalls.
    assign w_haz1  = hz.id_rs1_used && (hz.id_rs1 != '0) && blocking(w_cnt[hz.id_rs1]);
    assign w_haz2  = hz.id_rs2_used && (hz.id_rs2 != '0) && blocking(w_cnt[hz.id_rs2]);
    assign w_act   = rst_n && hz.en && hz.id_valid && !hz.flush;
    assign w_issue = w_act && !(w_haz1 || w_haz2);
    assign w_mark  = w_issue && hz.id_reg_wr && (hz.id_rd != '0);

    assign hz.stall     = w_act && (w_haz1 || w_haz2);
    assign hz.issue     = w_issue;
    assign hz.busy_mask = r_busy;
    assign hz.idle      = r_idle;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign w_cnt[gi]       = '0;
                assign w_busy_next[gi] = 1'b0;
            end else begin : g_cnt
                logic [CNT_W-1:0] r_cnt;
                logic [CNT_W-1:0] w_next;

                // A fresh issue to this register overrides its decrement: newest write wins.
                always_comb begin
                    w_next = r_cnt;
                    if (hz.en) begin
                        if (w_mark && (hz.id_rd == REG_ADDR_W'(gi)))
                            w_next = LAT;
                        else if (r_cnt != '0)
                            w_next = r_cnt - 1'b1;
                    end
                end

                always_ff @(posedge clk) begin
                    if (!rst_n)
                        r_cnt <= '0;
                    else
                        r_cnt <= w_next;
                end

                assign w_cnt[gi]       = r_cnt;
                assign w_busy_next[gi] = (w_next != '0);
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy <= '0;
            r_idle <= 1'b1;
        end else begin
            r_busy <= w_busy_next;
            r_idle <= ~|w_busy_next;
        end
    end
endmodule
